dbg_btn_event_reader: RTL

// Debug input reader; counterpart to the LED bar debug display. Samples N_CH raw

---
 rtl/dbg_btn_event_reader_if.sv | 11 +
 rtl/dbg_btn_event_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/dbg_btn_event_reader_if.sv
// Event handshake between the button reader (master) and its consumer (slave).
interface dbg_btn_event_reader_if #(
  parameter int DW = 3
);
  logic          evt_valid;
  logic          evt_ready;
  logic [DW-1:0] evt_data;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/dbg_btn_event_reader.sv
// Debug button reader: synchronises and debounces N_CH pins and queues
// press/release events in a small FIFO drained over a valid/ready handshake.
module dbg_btn_event_reader #(
  parameter int N_CH       = 4,
  parameter int DB_CYCLES  = 40000,
  parameter int FIFO_DEPTH = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                   clk_8M,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        btn_pin,
  output logic [N_CH-1:0]        btn_level,
  dbg_btn_event_reader_if.master evt,
  output logic                   evt_overflow,
  input  logic                   ovf_clr
);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DW = 1 + IW;
  localparam int CW = $clog2(DB_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [N_CH-1:0] REL_LEVEL = (ACTIVE_LOW != 0) ? '1 : '0;
  // Counter value on the edge that completes the debounce window.
  localparam logic [CW-1:0]   DB_LAST   = CW'(DB_CYCLES - 2);

  typedef enum logic [1:0] {REL, CHK_P, PRS, CHK_R} ch_state_t;

  ch_state_t       state [N_CH];
  logic [CW-1:0]   cnt   [N_CH];
  logic [N_CH-1:0] sync1, sync2, s;
  logic [N_CH-1:0] pend, pend_press, sel, push_mask;
  logic [IW-1:0]   push_ch;
  logic            found, push_en, push_is_press;
  logic [DW-1:0]   push_word;

  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [AW:0]     count, cnt_next;
  logic            full, pop, valid_q;
  logic [DW-1:0]   data_q;

  assign s = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Fixed-priority pick of the lowest pending channel, one push per cycle.
  always_comb begin
    sel     = '0;
    push_ch = '0;
    found   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (pend[i] && !found) begin
        found   = 1'b1;
        sel[i]  = 1'b1;
        push_ch = IW'(i);
      end
    end
    push_en       = found && !full;
    push_mask     = push_en ? sel : '0;
    push_is_press = |(pend_press & sel);
    push_word     = {push_is_press, push_ch};
  end

  // A new event on a channel whose previous one is still unqueued is dropped.
  always_ff @(posedge clk_8M) begin
    if (!rst_n) begin
      sync1 <= REL_LEVEL;
      sync2 <= REL_LEVEL;
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= REL;
        cnt[i]   <= '0;
      end
      pend         <= '0;
      pend_press   <= '0;
      btn_level    <= '0;
      evt_overflow <= 1'b0;
    end else begin
      sync1 <= btn_pin;
      sync2 <= sync1;
      pend  <= pend & ~push_mask;
      if (ovf_clr) evt_overflow <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        unique case (state[i])
          REL: if (s[i]) begin
            state[i] <= CHK_P;
            cnt[i]   <= '0;
          end
          CHK_P: begin
            if (!s[i]) begin
              state[i] <= REL;
            end else if (cnt[i] == DB_LAST) begin
              state[i]     <= PRS;
              btn_level[i] <= 1'b1;
              if (pend[i] && !push_mask[i]) begin
                evt_overflow <= 1'b1;
              end else begin
                pend[i]       <= 1'b1;
                pend_press[i] <= 1'b1;
              end
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          PRS: if (!s[i]) begin
            state[i] <= CHK_R;
            cnt[i]   <= '0;
          end
          CHK_R: begin
            if (s[i]) begin
              state[i] <= PRS;
            end else if (cnt[i] == DB_LAST) begin
              state[i]     <= REL;
              btn_level[i] <= 1'b0;
              if (pend[i] && !push_mask[i]) begin
                evt_overflow <= 1'b1;
              end else begin
                pend[i]       <= 1'b1;
                pend_press[i] <= 1'b0;
              end
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
          default: state[i] <= REL;
        endcase
      end
    end
  end

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = valid_q && evt.evt_ready;
  assign rd_next  = rd_ptr + AW'(pop);
  assign cnt_next = count + (AW+1)'(push_en) - (AW+1)'(pop);

  always_ff @(posedge clk_8M) begin
    if (push_en) mem[wr_ptr] <= push_word;
  end

  // Head is re-registered every cycle; a push into an emptying queue bypasses mem.
  always_ff @(posedge clk_8M) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_next;
      count   <= cnt_next;
      valid_q <= (cnt_next != '0);
      data_q  <= (push_en && (wr_ptr == rd_next)) ? push_word : mem[rd_next];
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_data  = data_q;
endmodule
